id_fwd_stage: RTL
=================

Name: id_fwd_stage

Overview:
- Parametrised decode-stage front end: IF->ID pipeline register, instruction hold buffer, register-file read, N-source operand forwarding, load-use interlock.
- Sits between IF and EX. Supplies resolved source operands and a stall request to the stall controller.
- Successor to the fixed 3-source OR-merge forwarding. Adds:
  - strict forwarding priority
  - r0 protection
  - load-use detection
  - an instruction skid buffer, so stalls do not lose synchronous-SRAM read data

Parameters:
- DATA_W, 32, operand/forward data width
- PC_W, 32, program counter width
- RA_W, 5, register address width
- NUM_FWD, 3, number of forwarding sources; index 0 = youngest (EX), highest priority

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- stall_in  in  1  external stall of this stage (stall controller)
- flush  in  1  discard held instruction
- if_valid  in  1  IF bundle valid
- if_pc  in  PC_W  IF pc
- if_inst  in  32  instruction SRAM read data, aligned with the registered pc
- rf_raddr1  out  RA_W  = inst[25:21]
- rf_raddr2  out  RA_W  = inst[20:16]
- rf_rdata1  in  DATA_W  regfile read data for rf_raddr1
- rf_rdata2  in  DATA_W  regfile read data for rf_raddr2
- fwd_we  in  NUM_FWD  per-source write enable
- fwd_waddr  in  NUM_FWD*RA_W  per-source destination; source k at [k*RA_W +: RA_W]
- fwd_wdata  in  NUM_FWD*DATA_W  per-source result
- fwd_pend  in  NUM_FWD  per-source result not yet available (load in flight)
- out_valid  out  1  bundle to EX valid
- out_pc  out  PC_W  held pc
- out_inst  out  32  current instruction
- out_src1  out  DATA_W  resolved rs operand
- out_src2  out  DATA_W  resolved rt operand
- stallreq  out  1  load-use interlock request

Behaviour:
- Reset (rst==0 at posedge):
  - r_valid=0, r_pc=0, inst_buf=0, state=RUN.
  - Outputs in the cycle after reset: out_valid=0, out_pc=0, out_inst=if_inst, stallreq=0.
- stall_any = stall_in | stallreq.
- Pipeline register, at posedge, priority order:
  - flush: r_valid<=0, state<=RUN
  - else if stall_any: hold r_valid, r_pc
  - else: r_valid<=if_valid, r_pc<=if_pc
- Hold FSM, states RUN and HOLD:
  - RUN & stall_any & !flush -> HOLD; inst_buf<=if_inst.
  - HOLD & !stall_any -> RUN.
  - HOLD & stall_any -> stay in HOLD; inst_buf unchanged.
  - flush from either state -> RUN.
  - cur_inst = (state==HOLD) ? inst_buf : if_inst.
- Forwarding, per operand with address a (rs or rt):
  - Source k matches when fwd_we[k] && fwd_waddr[k]==a && a!=0.
  - The lowest-index match wins. No match -> rf_rdata.
  - a==0 -> result is 0, regardless of regfile contents.
- Interlock:
  - stallreq = r_valid & (winning match for rs or rt has fwd_pend=1).
  - Only the winning source is checked; a pending older source shadowed by a younger non-pending match does not stall.
- Outputs (combinational):
  - out_valid = r_valid & !stallreq & !stall_in & !flush. A bubble presents out_valid=0 with other fields don't-care.
  - out_inst = cur_inst, out_pc = r_pc.
  - Latency IF->EX bundle: 1 cycle.
- Simultaneous events:
  - flush with stall: flush wins.
  - stallreq with stall_in: both hold; exit occurs only when both are low.
  - A reset mid-HOLD returns to RUN and drops the held instruction.

Optional Feature:
- ID_FWD_EN.
- Defined: forwarding as specified.
- Undefined:
  - Forwarding mux removed; out_src = rf_rdata, or 0 for r0.
  - stallreq asserts on any matching source regardless of fwd_pend, and holds until no source matches.

Test Plan:
- Reset: rst=0 two cycles, then 1 -> out_valid=0, out_pc=0, stallreq=0, state RUN.
- Forward priority:
  - Setup: rs=5, fwd0=(we=1,addr=5,data=0x11), fwd2=(1,5,0x33), rf_rdata1=0x99.
  - Check: out_src1=0x11.
  - Then drop fwd0.we -> out_src1=0x33.
- r0 guard: rt=0, fwd0=(1,0,0xDEAD), rf_rdata2=0x7 -> out_src2=0.
- Load-use:
  - Setup: rs=8, fwd0=(1,8,x,pend=1).
  - Check: stallreq=1, out_valid=0, r_pc held.
  - Next cycle pend=0, data=0x42 -> stallreq=0, out_src1=0x42, same pc 0x1000.
- Skid buffer:
  - Setup: inst 0x3C010001 at pc 0x1004; stall_in=1 for 3 cycles while if_inst changes to 0xFFFFFFFF.
  - Check: out_inst stays 0x3C010001; on release out_valid=1 with that inst.
- Flush during HOLD: flush=1 with stall_in=1 -> next cycle r_valid=0, state RUN, out_valid=0.

Source files
------------

// File: rtl/id_fwd_stage.sv
// ---------------------------------------------------------------------------
// id_fwd_stage -- decode-stage front end
//
// Sits between IF and EX and holds the IF->ID pipeline register. It keeps a
// one-entry instruction skid buffer, so a stall does not lose the synchronous
// SRAM read data. It reads the register file and resolves both source
// operands through an N-source forwarding network with strict priority. It
// also raises a load-use interlock request towards the stall controller.
//
// Configuration macro: ID_FWD_EN
//   defined   : full forwarding. The lowest-index matching source wins, and
//               the stage stalls only when that winning source is still
//               pending.
//   undefined : no forwarding mux. Operands come straight from the register
//               file. stallreq is raised while any enabled source targets
//               rs or rt.
//
// Ports
//   clk, rst               clock, synchronous active-low reset
//   stall_in               external stall of this stage
//   flush                  discard the instruction held in ID
//   if_valid, if_pc        IF bundle, captured into the pipeline register
//   if_inst                instruction SRAM data, aligned with the registered pc
//   rf_raddr1/2            register-file read addresses (rs, rt)
//   rf_rdata1/2            register-file read data
//   fwd_we/waddr/wdata     per-source forwarding bus; source k at slice k
//   fwd_pend               per-source "result not available yet" (load)
//   out_valid/pc/inst      bundle to EX
//   out_src1/2             resolved rs / rt operands
//   stallreq               load-use interlock request
// ---------------------------------------------------------------------------
module id_fwd_stage #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int RA_W    = 5,
  parameter int NUM_FWD = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_in,
  input  logic                      flush,
  input  logic                      if_valid,
  input  logic [PC_W-1:0]           if_pc,
  input  logic [31:0]               if_inst,
  output logic [RA_W-1:0]           rf_raddr1,
  output logic [RA_W-1:0]           rf_raddr2,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*RA_W-1:0]   fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_pend,
  output logic                      out_valid,
  output logic [PC_W-1:0]           out_pc,
  output logic [31:0]               out_inst,
  output logic [DATA_W-1:0]         out_src1,
  output logic [DATA_W-1:0]         out_src2,
  output logic                      stallreq
);

  // RUN : ID shows the SRAM output directly.
  // HOLD: the SRAM has already moved on, so ID shows the captured copy.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              capture;

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [31:0]       inst_buf;
  logic [31:0]       cur_inst;

  logic              stall_any;
  logic [RA_W-1:0]   rs;
  logic [RA_W-1:0]   rt;
  logic [NUM_FWD-1:0] hit_rs;
  logic [NUM_FWD-1:0] hit_rt;

  // -------------------------------------------------------------------------
  // Current instruction and register addresses
  // -------------------------------------------------------------------------
  assign cur_inst  = (state == HOLD) ? inst_buf : if_inst;
  assign rs        = RA_W'(cur_inst[25:21]);
  assign rt        = RA_W'(cur_inst[20:16]);
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // -------------------------------------------------------------------------
  // Per-source match vectors. r0 is hard-wired to zero, so a write to r0
  // must never be seen as a producer.
  // -------------------------------------------------------------------------
  // NOTE: every signal an always_comb writes gets a default first. A path
  // that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    hit_rs = '0;
    hit_rt = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      hit_rs[k] = fwd_we[k] && (fwd_waddr[k*RA_W +: RA_W] == rs) && (rs != '0);
      hit_rt[k] = fwd_we[k] && (fwd_waddr[k*RA_W +: RA_W] == rt) && (rt != '0);
    end
  end

`ifdef ID_FWD_EN
  // -------------------------------------------------------------------------
  // Priority forwarding. The loop walks from the oldest source to the
  // youngest, so the lowest-index match is written last and wins. Only the
  // winning source's pend flag counts: a younger ready result shadows an
  // older load to the same register.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] fwd_rs_data;
  logic [DATA_W-1:0] fwd_rt_data;
  logic              pend_rs;
  logic              pend_rt;

  always_comb begin
    fwd_rs_data = '0;
    fwd_rt_data = '0;
    pend_rs     = 1'b0;
    pend_rt     = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (hit_rs[k]) begin
        fwd_rs_data = fwd_wdata[k*DATA_W +: DATA_W];
        pend_rs     = fwd_pend[k];
      end
      if (hit_rt[k]) begin
        fwd_rt_data = fwd_wdata[k*DATA_W +: DATA_W];
        pend_rt     = fwd_pend[k];
      end
    end
  end

  assign out_src1 = (rs == '0) ? '0 : ((|hit_rs) ? fwd_rs_data : rf_rdata1);
  assign out_src2 = (rt == '0) ? '0 : ((|hit_rt) ? fwd_rt_data : rf_rdata2);
  assign stallreq = r_valid & (pend_rs | pend_rt);
`else
  // -------------------------------------------------------------------------
  // No forwarding network. Any in-flight producer of rs or rt interlocks the
  // stage until it has retired to the register file.
  // -------------------------------------------------------------------------
  logic unused_fwd;
  assign unused_fwd = ^{fwd_wdata, fwd_pend};

  assign out_src1 = (rs == '0) ? '0 : rf_rdata1;
  assign out_src2 = (rt == '0) ? '0 : rf_rdata2;
  assign stallreq = r_valid & ((|hit_rs) | (|hit_rt));
`endif

  // -------------------------------------------------------------------------
  // Hold FSM. A flush always returns to RUN, whatever stalls are active.
  // The SRAM word is captured only on entry to HOLD. Later stall cycles see
  // a newer word that does not belong to r_pc.
  // -------------------------------------------------------------------------
  assign stall_any = stall_in | stallreq;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (flush) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (stall_any) begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end
        end
        HOLD: begin
          if (!stall_any) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever the order of the statements.
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // IF->ID pipeline register and skid buffer. r_pc is left alone on a flush,
  // because r_valid=0 already marks the slot empty.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      inst_buf <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (!stall_any) begin
        r_valid <= if_valid;
        r_pc    <= if_pc;
      end
      if (capture) inst_buf <= if_inst;
    end
  end

  // -------------------------------------------------------------------------
  // Bundle to EX. Any stall or flush turns the current slot into a bubble.
  // -------------------------------------------------------------------------
  assign out_valid = r_valid & ~stallreq & ~stall_in & ~flush;
  assign out_pc    = r_pc;
  assign out_inst  = cur_inst;

endmodule
